branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
Sequencing controller for the ID-stage branch/jump resolution unit of the 5-stage MIPS core. It detects operand hazards on branch source registers and holds the front end until the operands are valid. It then issues the PC redirect using the taken/target results from the branch unit and tracks the architectural delay slot. It also keeps branch and taken-branch performance counters.

Parameters:
CNT_W, 32, width of the perf counters branch_cnt and taken_cnt (wrap on overflow)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID stage holds a valid instruction this cycle
id_is_branch  in  1  ID instruction is a conditional branch (beq/bne/bgtz/...)
id_is_jump  in  1  ID instruction is an unconditional jump (j/jal)
id_rs  in  5  branch source register A
id_rt  in  5  branch source register B
id_uses_rt  in  1  branch compares rt (beq/bne)
ex_wreg  in  1  EX instruction writes a register
ex_waddr  in  5  EX destination register
mem_wreg  in  1  MEM instruction writes a register
mem_waddr  in  5  MEM destination register
mem_is_load  in  1  MEM instruction is a load
taken  in  1  branch condition true (from branch unit zero/bgtz signals)
target  in  32  branch/jump target address from branch unit
pipe_stall  in  1  global stall from memory side; freezes this block
stall_req  out  1  hold PC/IF/ID, insert bubble into EX
pc_redirect  out  1  load PC with redirect_addr at end of this cycle
redirect_addr  out  32  redirect target
in_delay_slot  out  1  current ID instruction is a delay-slot instruction
branch_cnt  out  CNT_W  resolved branches+jumps
taken_cnt  out  CNT_W  resolved redirects

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; in_delay_slot=0; branch_cnt=0; taken_cnt=0. The combinational outputs stall_req, pc_redirect and redirect_addr read 0 while the state is IDLE and there is no request.
- ctl = id_valid & (id_is_branch | id_is_jump).
- The hazard check applies to rs, and to rt only when id_uses_rt=1 and the instruction is a branch. Register 0 never causes a hazard.
  - A match in EX hazards when ex_wreg=1 and ex_waddr equals the source. There is no EX→ID forward for the compare.
  - A match in MEM hazards when mem_wreg=1, mem_is_load=1 and mem_waddr equals the source.
  - A non-load MEM result is forwarded and does not stall.
  - Jumps never hazard.
- hazard is recomputed every cycle. No stall cycle count is stored.
- FSM states: IDLE, WAIT, SLOT.
  - IDLE: if ctl & hazard, then stall_req=1 and go to WAIT. If ctl & !hazard, the instruction resolves this cycle and goes to SLOT.
  - WAIT: stall_req=1 while hazard persists. The first cycle with !hazard resolves and goes to SLOT.
  - SLOT: waits for the next accepted ID instruction (id_valid=1, stall_req=0), then returns to IDLE.
    - in_delay_slot=1 for exactly that instruction.
    - A branch/jump seen in SLOT is treated as an ordinary instruction: no redirect, no count, no stall.
- Resolve cycle (combinational, same cycle):
  - pc_redirect = id_is_jump | taken.
  - redirect_addr = target when pc_redirect=1, else 0.
  - branch_cnt += 1; taken_cnt += 1 if pc_redirect.
  - The instruction already in IF is the delay slot and is not flushed.
- pipe_stall=1:
  - State, counters and in_delay_slot hold.
  - pc_redirect is forced to 0 and resolution is deferred to the first cycle with pipe_stall=0.
  - stall_req still reflects hazard, so it stays asserted in WAIT.
- Simultaneous hazard and pipe_stall: stay in the current state; no counter change.
- rst during WAIT or SLOT: return to IDLE next edge, drop stall_req, clear in_delay_slot, zero counters.
- Counters wrap modulo 2^CNT_W.

Test Plan:
1. beq $1,$2 with no writers in flight, taken=1, target=0x0040_0020 → pc_redirect=1 and redirect_addr=0x0040_0020 in the same cycle; next accepted ID has in_delay_slot=1; branch_cnt=1, taken_cnt=1.
2. bne $3,$4 while EX writes $4 via ALU → stall_req=1 for 1 cycle; resolves next cycle with taken=0, so pc_redirect=0; branch_cnt=1, taken_cnt=0.
3. lw $5 in EX, then bgtz $5 in ID → 1 cycle stall (EX match), 1 more cycle (MEM load match), total 2 stall cycles; resolves on cycle 3.
4. Writers to $0 in EX/MEM with beq $0,$0 → no stall; j 0x0040_1000 with EX writing $rs → no stall, redirect to 0x0040_1000.
5. pipe_stall=1 for 3 cycles during a resolvable branch → pc_redirect=0 and counters unchanged throughout; redirect fires on the cycle pipe_stall falls.
6. Branch in delay slot (SLOT state) → no redirect, branch_cnt unchanged. Separately, rst asserted in WAIT → stall_req=0 and counters=0 next cycle. Preload branch_cnt=2^CNT_W−1 → wraps to 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// ID-stage branch/jump sequencer: holds the front end on compare-operand hazards,
// issues the PC redirect on resolution, tracks the delay slot and counts branches.
module branch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_is_jump,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_wreg,
  input  logic [4:0]       ex_waddr,
  input  logic             mem_wreg,
  input  logic [4:0]       mem_waddr,
  input  logic             mem_is_load,
  input  logic             taken,
  input  logic [31:0]      target,
  input  logic             pipe_stall,
  output logic             stall_req,
  output logic             pc_redirect,
  output logic [31:0]      redirect_addr,
  output logic             in_delay_slot,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, SLOT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic ctl, rs_haz, rt_haz, hazard, resolve;

  assign ctl = id_valid && (id_is_branch || id_is_jump);

  // EX results are never forwarded to the compare; MEM results are, unless still a load.
  assign rs_haz = (id_rs != 5'd0) &&
                  ((ex_wreg && (ex_waddr == id_rs)) ||
                   (mem_wreg && mem_is_load && (mem_waddr == id_rs)));
  assign rt_haz = (id_rt != 5'd0) &&
                  ((ex_wreg && (ex_waddr == id_rt)) ||
                   (mem_wreg && mem_is_load && (mem_waddr == id_rt)));
  assign hazard = ctl && id_is_branch && (rs_haz || (id_uses_rt && rt_haz));

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    resolve   = 1'b0;
    unique case (state_q)
      IDLE, WAIT: begin
        if (ctl) begin
          if (hazard) begin
            stall_req = 1'b1;
            if (!pipe_stall) state_d = WAIT;
          end else if (!pipe_stall) begin
            resolve = 1'b1;
            state_d = SLOT;
          end
        end else if (!pipe_stall) begin
          state_d = IDLE;
        end
      end
      SLOT: begin
        if (id_valid && !pipe_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pc_redirect   = resolve && (id_is_jump || taken);
    redirect_addr = pc_redirect ? target : 32'd0;

    branch_cnt_d = branch_cnt_q + (resolve ? CNT_W'(1) : CNT_W'(0));
    taken_cnt_d  = taken_cnt_q + (pc_redirect ? CNT_W'(1) : CNT_W'(0));
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign in_delay_slot = (state_q == SLOT);
  assign branch_cnt    = branch_cnt_q;
  assign taken_cnt     = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a rule-level reference model.
module tb_branch_ctrl;

  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_is_branch, id_is_jump, id_uses_rt;
  logic [4:0]  id_rs, id_rt, ex_waddr, mem_waddr;
  logic        ex_wreg, mem_wreg, mem_is_load, taken, pipe_stall;
  logic [31:0] target;
  logic        stall_req, pc_redirect, in_delay_slot;
  logic [31:0] redirect_addr;
  logic [CNT_W-1:0] branch_cnt, taken_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a pending delay slot flag plus plain integer counters.
  bit m_slot;
  int m_bcnt, m_tcnt;

  always #5 clk = ~clk;

  branch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_is_load(mem_is_load),
    .taken(taken), .target(target), .pipe_stall(pipe_stall),
    .stall_req(stall_req), .pc_redirect(pc_redirect), .redirect_addr(redirect_addr),
    .in_delay_slot(in_delay_slot), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_blocked(input logic [4:0] src);
    if (src == 5'd0) return 1'b0;
    if (ex_wreg && ex_waddr == src) return 1'b1;
    if (mem_wreg && mem_is_load && mem_waddr == src) return 1'b1;
    return 1'b0;
  endfunction

  // Outputs are compared 1ns after inputs settle (mid low phase); model advances at the edge.
  task automatic step();
    bit ctl, haz, redir;
    #1;
    ctl   = id_valid && (id_is_branch || id_is_jump);
    haz   = ctl && id_is_branch && (src_blocked(id_rs) || (id_uses_rt && src_blocked(id_rt)));
    redir = !m_slot && ctl && !haz && !pipe_stall && (id_is_jump || taken);
    if (!rst) begin
      check("stall_req",     32'(stall_req),     32'(!m_slot && haz));
      check("pc_redirect",   32'(pc_redirect),   32'(redir));
      check("redirect_addr", redirect_addr,      redir ? target : 32'd0);
      check("in_delay_slot", 32'(in_delay_slot), 32'(m_slot));
      check("branch_cnt",    32'(branch_cnt),    32'(m_bcnt));
      check("taken_cnt",     32'(taken_cnt),     32'(m_tcnt));
    end
    if (rst) begin
      m_slot = 1'b0; m_bcnt = 0; m_tcnt = 0;
    end else if (!pipe_stall) begin
      if (m_slot) begin
        if (id_valid) m_slot = 1'b0;
      end else if (ctl && !haz) begin
        m_bcnt = (m_bcnt + 1) % CMOD;
        if (redir) m_tcnt = (m_tcnt + 1) % CMOD;
        m_slot = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 1'b0; id_valid = 1'b0; id_is_branch = 1'b0; id_is_jump = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_wreg = 1'b0; ex_waddr = '0;
    mem_wreg = 1'b0; mem_waddr = '0; mem_is_load = 1'b0; taken = 1'b0;
    target = '0; pipe_stall = 1'b0;
  endtask

  task automatic branch(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic tk, input logic [31:0] tgt);
    id_valid = 1'b1; id_is_branch = 1'b1; id_is_jump = 1'b0;
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; taken = tk; target = tgt;
  endtask

  task automatic plain_instr();
    id_valid = 1'b1; id_is_branch = 1'b0; id_is_jump = 1'b0; taken = 1'b0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int stalls, fires;
    quiet();
    @(negedge clk);
    do_reset();

    // Reset state with no request
    check("rst_cnt", 32'(branch_cnt), 32'd0);
    step();

    // 1: taken beq, no writers in flight
    branch(5'd1, 5'd2, 1'b1, 1'b1, 32'h0040_0020);
    #1 check("t1_addr", redirect_addr, 32'h0040_0020);
    step();
    plain_instr();
    #1 check("t1_slot", 32'(in_delay_slot), 32'd1);
    step();
    quiet();
    #1 check("t1_bcnt", 32'(branch_cnt), 32'd1);
    check("t1_tcnt", 32'(taken_cnt), 32'd1);
    step();

    // 2: bne with EX writing rt, resolves not-taken after one stall
    do_reset();
    branch(5'd3, 5'd4, 1'b1, 1'b0, 32'h1234);
    ex_wreg = 1'b1; ex_waddr = 5'd4;
    #1 check("t2_stall", 32'(stall_req), 32'd1);
    step();
    ex_wreg = 1'b0;
    step();
    plain_instr(); step();
    quiet();
    #1 check("t2_bcnt", 32'(branch_cnt), 32'd1);
    check("t2_tcnt", 32'(taken_cnt), 32'd0);
    step();

    // 3: lw $5 ahead of bgtz $5: EX match then MEM-load match
    branch(5'd5, 5'd0, 1'b0, 1'b1, 32'h0040_0100);
    ex_wreg = 1'b1; ex_waddr = 5'd5;
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        ex_wreg = 1'b0; mem_wreg = 1'b1; mem_waddr = 5'd5; mem_is_load = 1'b1;
      end else if (c == 2) begin
        mem_wreg = 1'b0; mem_is_load = 1'b0;
      end
      #1 if (stall_req) stalls++;
      if (c == 2) check("t3_resolve", 32'(pc_redirect), 32'd1);
      step();
    end
    check("t3_stalls", 32'(stalls), 32'd2);
    plain_instr(); step();

    // 4: $0 writers never hazard; jumps ignore hazards
    quiet();
    branch(5'd0, 5'd0, 1'b1, 1'b1, 32'h0040_0800);
    ex_wreg = 1'b1; mem_wreg = 1'b1; mem_is_load = 1'b1;
    #1 check("t4_zero", 32'(stall_req), 32'd0);
    step();
    plain_instr(); step();
    quiet();
    id_valid = 1'b1; id_is_jump = 1'b1; id_rs = 5'd7; target = 32'h0040_1000;
    ex_wreg = 1'b1; ex_waddr = 5'd7;
    #1 check("t4_jaddr", redirect_addr, 32'h0040_1000);
    step();
    plain_instr(); step();

    // 5: pipe_stall holds a resolvable branch for 3 cycles
    quiet();
    branch(5'd1, 5'd2, 1'b1, 1'b1, 32'h0040_2000);
    pipe_stall = 1'b1;
    fires = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) pipe_stall = 1'b0;
      #1 if (pc_redirect) fires++;
      step();
    end
    check("t5_fires", 32'(fires), 32'd1);

    // 6a: branch in delay slot is an ordinary instruction
    branch(5'd1, 5'd2, 1'b1, 1'b1, 32'h0040_3000);
    #1 check("t6_noredir", 32'(pc_redirect), 32'd0);
    step();

    // 6b: reset while waiting
    quiet();
    branch(5'd6, 5'd0, 1'b0, 1'b1, 32'h0);
    ex_wreg = 1'b1; ex_waddr = 5'd6;
    step(); step();
    rst = 1'b1; step();
    quiet();
    #1 check("t6_rst_stall", 32'(stall_req), 32'd0);
    check("t6_rst_cnt", 32'(branch_cnt), 32'd0);
    step();

    // 6c: counter wrap after 2^CNT_W resolves
    for (int k = 0; k < CMOD; k++) begin
      quiet(); id_valid = 1'b1; id_is_jump = 1'b1; target = 32'(k * 4);
      step();
      plain_instr(); step();
    end
    quiet();
    #1 check("t6_wrap", 32'(branch_cnt), 32'd0);
    step();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 199) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_is_branch = ($urandom_range(0, 1) == 1);
      id_is_jump   = !id_is_branch && ($urandom_range(0, 2) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom);
      ex_wreg      = 1'($urandom);
      ex_waddr     = 5'($urandom_range(0, 3));
      mem_wreg     = 1'($urandom);
      mem_waddr    = 5'($urandom_range(0, 3));
      mem_is_load  = 1'($urandom);
      taken        = 1'($urandom);
      target       = $urandom;
      pipe_stall   = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
